// File: rtl/sram_pkg.sv
// sram_pkg: state encoding, port selects and default timing shared by the SRAM responder files.
package sram_pkg;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;
    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_VID    = 1'b1;
    localparam int   RD_WAIT_DEF = 2;
    localparam int   WR_WAIT_DEF = 2;
    localparam int   TURN_DEF    = 1;
endpackage

// File: rtl/sram_req_arb.sv
// sram_req_arb: per-port pending request latches and the fixed video-first grant.
module sram_req_arb import sram_pkg::*; #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_r,
    input  logic              i_cpu_w,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    input  logic              i_idle,
    output logic              o_grant,
    output logic              o_port,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_write
);
    logic              r_cpu_pend;
    logic              r_cpu_write;
    logic [ADDR_W-1:0] r_cpu_addr;
    logic [DATA_W-1:0] r_cpu_wdata;
    logic              r_vid_pend;
    logic [ADDR_W-1:0] r_vid_addr;

    assign o_grant = i_idle && (r_vid_pend || r_cpu_pend);
    assign o_port  = r_vid_pend ? PORT_VID : PORT_CPU;
    assign o_addr  = (o_port == PORT_VID) ? r_vid_addr : r_cpu_addr;
    assign o_wdata = r_cpu_wdata;
    assign o_write = (o_port == PORT_CPU) && r_cpu_write;

    // A pulse seen while the same port is still pending is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cpu_pend  <= 1'b0;
            r_cpu_write <= 1'b0;
            r_cpu_addr  <= '0;
            r_cpu_wdata <= '0;
            r_vid_pend  <= 1'b0;
            r_vid_addr  <= '0;
        end else begin
            if (!r_cpu_pend && (i_cpu_r || i_cpu_w)) begin
                r_cpu_pend  <= 1'b1;
                r_cpu_write <= i_cpu_w;
                r_cpu_addr  <= i_cpu_addr;
                r_cpu_wdata <= i_cpu_wdata;
            end else if (o_grant && o_port == PORT_CPU) begin
                r_cpu_pend <= 1'b0;
            end
            if (!r_vid_pend && i_vid_req) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= i_vid_addr;
            end else if (o_grant && o_port == PORT_VID) begin
                r_vid_pend <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: serves CPU read/write and video read requests from an async 8-bit SRAM
// with parameterised read wait, write-enable width and write-to-read turnaround.
module sram_responder import sram_pkg::*; #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF,
    parameter int TURN    = TURN_DEF
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic [ADDR_W-1:0] iCpuRamAddr,
    input  logic [DATA_W-1:0] iCpuRamDataW,
    input  logic              iCpuRamR,
    input  logic              iCpuRamW,
    output logic [DATA_W-1:0] oCpuRamDataR,
    output logic              oCpuRamReady,
    input  logic              iVidReq,
    input  logic [ADDR_W-1:0] iVidAddr,
    output logic [DATA_W-1:0] oVidData,
    output logic              oVidAck,
    output logic [ADDR_W-1:0] oSramAddr,
    inout  wire  [DATA_W-1:0] ioSramData,
    output logic              oSramWe
);
    localparam logic [3:0] RD_LAST   = 4'(RD_WAIT);
    localparam logic [3:0] WR_LAST   = 4'(WR_WAIT);
    localparam logic [3:0] TURN_LAST = 4'(TURN - 1);
    localparam state_t     WR_EXIT   = (TURN == 0) ? S_IDLE : S_TURN;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              w_done;
    logic              w_grant, w_port, w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              r_port;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_cpu_rdata, r_vid_rdata;
    logic              r_cpu_ready, r_vid_ack;

    sram_req_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
        .i_clk       (iClk),
        .i_rst_n     (iRstN),
        .i_cpu_r     (iCpuRamR),
        .i_cpu_w     (iCpuRamW),
        .i_cpu_addr  (iCpuRamAddr),
        .i_cpu_wdata (iCpuRamDataW),
        .i_vid_req   (iVidReq),
        .i_vid_addr  (iVidAddr),
        .i_idle      (r_state == S_IDLE),
        .o_grant     (w_grant),
        .o_port      (w_port),
        .o_addr      (w_addr),
        .o_wdata     (w_wdata),
        .o_write     (w_write)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 4'd1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_grant) w_state_nxt = w_write ? S_WRITE : S_READ;
            end
            S_READ: if (r_cnt == RD_LAST) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_done      = 1'b1;
            end
            S_WRITE: if (r_cnt == WR_LAST) begin
                w_state_nxt = WR_EXIT;
                w_cnt_nxt   = '0;
                w_done      = 1'b1;
            end
            S_TURN: if (r_cnt == TURN_LAST) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_port      <= PORT_CPU;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_vid_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cpu_ready <= w_done && r_port == PORT_CPU;
            r_vid_ack   <= w_done && r_port == PORT_VID;
            if (r_state == S_IDLE && w_grant) begin
                r_addr  <= w_addr;
                r_port  <= w_port;
                r_wdata <= w_wdata;
            end
            if (w_done && r_state == S_READ) begin
                if (r_port == PORT_VID) r_vid_rdata <= ioSramData;
                else r_cpu_rdata <= ioSramData;
            end
        end
    end

    // Pin controls decode straight from reset-cleared state so reset releases the bus at once.
    assign oSramWe      = (r_state == S_WRITE) && (r_cnt < WR_LAST);
    assign ioSramData   = (r_state == S_WRITE) ? r_wdata : {DATA_W{1'bz}};
    assign oSramAddr    = r_addr;
    assign oCpuRamDataR = r_cpu_rdata;
    assign oVidData     = r_vid_rdata;
    assign oCpuRamReady = r_cpu_ready;
    assign oVidAck      = r_vid_ack;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench for sram_responder driving an async SRAM model on the data pins.
module tb_sram_responder;
    localparam int AW = 20, DW = 8, RDW = 2, WRW = 2, TRN = 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        logic       rd;
    } exp_t;

    logic          iClk = 1'b0, iRstN = 1'b0;
    logic [AW-1:0] iCpuRamAddr = '0, iVidAddr = '0;
    logic [DW-1:0] iCpuRamDataW = '0;
    logic          iCpuRamR = 1'b0, iCpuRamW = 1'b0, iVidReq = 1'b0;
    logic [DW-1:0] oCpuRamDataR, oVidData;
    logic          oCpuRamReady, oVidAck, oSramWe;
    logic [AW-1:0] oSramAddr;
    wire  [DW-1:0] ioSramData;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          we_d = 1'b0, probe = 1'b0;
    int            cyc = 0, n_checks = 0, n_fail = 0;
    exp_t          cpu_q[$], vid_q[$];

    sram_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW), .TURN(TRN)) dut (
        .iClk         (iClk),
        .iRstN        (iRstN),
        .iCpuRamAddr  (iCpuRamAddr),
        .iCpuRamDataW (iCpuRamDataW),
        .iCpuRamR     (iCpuRamR),
        .iCpuRamW     (iCpuRamW),
        .oCpuRamDataR (oCpuRamDataR),
        .oCpuRamReady (oCpuRamReady),
        .iVidReq      (iVidReq),
        .iVidAddr     (iVidAddr),
        .oVidData     (oVidData),
        .oVidAck      (oVidAck),
        .oSramAddr    (oSramAddr),
        .ioSramData   (ioSramData),
        .oSramWe      (oSramWe)
    );

    // SRAM outputs data unless a write is in progress or just ended; probe forces a known value.
    assign ioSramData = probe ? 8'h5A : (!oSramWe && !we_d) ? mem[oSramAddr] : 8'bz;

    function automatic logic [7:0] pat(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h96;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial forever #5 iClk = ~iClk;
    initial forever begin
        @(posedge iClk);
        cyc++;
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = pat(20'(i));
        mem[20'h12345] = 8'hA5;
        forever begin
            @(posedge iClk);
            if (oSramWe) mem[oSramAddr] <= ioSramData;
            we_d <= oSramWe;
        end
    end

    initial begin
        int we_run;
        logic [AW-1:0] we_addr;
        exp_t e;
        we_run = 0;
        we_addr = '0;
        forever begin
            @(negedge iClk);
            if (!iRstN) begin
                we_run = 0;
            end else begin
                if (oCpuRamReady || oVidAck) check_eq("ready_ack_overlap", 32'(oCpuRamReady & oVidAck), 0);
                if (oCpuRamReady) begin
                    check_eq("cpu_ready_expected", 32'(cpu_q.size() > 0), 1);
                    if (cpu_q.size() > 0) begin
                        e = cpu_q.pop_front();
                        check_eq("cpu_ready_cycle", 32'(cyc), 32'(e.cyc));
                        if (e.rd) check_eq("cpu_rdata", 32'(oCpuRamDataR), 32'(e.data));
                    end
                end
                if (oVidAck) begin
                    check_eq("vid_ack_expected", 32'(vid_q.size() > 0), 1);
                    if (vid_q.size() > 0) begin
                        e = vid_q.pop_front();
                        check_eq("vid_ack_cycle", 32'(cyc), 32'(e.cyc));
                        check_eq("vid_data", 32'(oVidData), 32'(e.data));
                    end
                end
                if (oSramWe) begin
                    if (we_run == 0) we_addr = oSramAddr;
                    else check_eq("we_addr_stable", 32'(oSramAddr), 32'(we_addr));
                    we_run++;
                end else if (we_run > 0) begin
                    check_eq("we_width", 32'(we_run), 32'(WRW));
                    we_run = 0;
                end
            end
        end
    end

    task automatic pulse_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        iCpuRamR = r;
        iCpuRamW = w;
        iCpuRamAddr = a;
        iCpuRamDataW = d;
        @(negedge iClk);
        iCpuRamR = 1'b0;
        iCpuRamW = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (cpu_q.size() + vid_q.size()) > 0; i++) @(negedge iClk);
        check_eq("scoreboard_drained", 32'(cpu_q.size() + vid_q.size()), 0);
        repeat (3) @(negedge iClk);
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge iClk);
        iRstN = 1'b1;
        @(negedge iClk);
        check_eq("rst_addr", 32'(oSramAddr), 0);
        check_eq("rst_cpu_data", 32'(oCpuRamDataR), 0);
        check_eq("rst_vid_data", 32'(oVidData), 0);
        check_eq("rst_ready", 32'(oCpuRamReady), 0);
        check_eq("rst_ack", 32'(oVidAck), 0);
        check_eq("rst_we", 32'(oSramWe), 0);

        // CPU read, address appears two cycles after the pulse, data five cycles after
        c0 = cyc;
        cpu_q.push_back('{8'hA5, c0 + 5, 1'b1});
        pulse_cpu(1'b1, 1'b0, 20'h12345, 8'h00);
        check_eq("rd_addr_before_grant", 32'(oSramAddr), 0);
        @(negedge iClk);
        check_eq("rd_addr", 32'(oSramAddr), 32'h12345);
        drain();

        // CPU write, with a read queued during the hold cycle to expose the turnaround
        c0 = cyc;
        cpu_q.push_back('{8'h00, c0 + 5, 1'b0});
        pulse_cpu(1'b0, 1'b1, 20'h00010, 8'h3C);
        @(negedge iClk);
        check_eq("wr_we_first", 32'(oSramWe), 1);
        check_eq("wr_data_first", 32'(ioSramData), 32'h3C);
        check_eq("wr_addr", 32'(oSramAddr), 32'h10);
        repeat (2) @(negedge iClk);
        check_eq("wr_hold_we", 32'(oSramWe), 0);
        check_eq("wr_hold_data", 32'(ioSramData), 32'h3C);
        cpu_q.push_back('{8'h3C, c0 + 10, 1'b1});
        pulse_cpu(1'b1, 1'b0, 20'h00010, 8'h00);
        drain();

        // Video and CPU in the same cycle: video first, CPU on the very next idle cycle
        c0 = cyc;
        vid_q.push_back('{pat(20'h00020), c0 + 5, 1'b1});
        cpu_q.push_back('{pat(20'h00777), c0 + 9, 1'b1});
        iVidReq = 1'b1;
        iVidAddr = 20'h00020;
        pulse_cpu(1'b1, 1'b0, 20'h00777, 8'h00);
        iVidReq = 1'b0;
        drain();

        // Read and write together: the write wins
        c0 = cyc;
        cpu_q.push_back('{8'h00, c0 + 5, 1'b0});
        pulse_cpu(1'b1, 1'b1, 20'h00030, 8'h77);
        drain();
        c0 = cyc;
        cpu_q.push_back('{8'h77, c0 + 5, 1'b1});
        pulse_cpu(1'b1, 1'b0, 20'h00030, 8'h00);
        drain();

        // Second CPU pulse while the first waits behind video is dropped
        c0 = cyc;
        vid_q.push_back('{pat(20'h00100), c0 + 5, 1'b1});
        cpu_q.push_back('{pat(20'h00200), c0 + 9, 1'b1});
        iVidReq = 1'b1;
        iVidAddr = 20'h00100;
        pulse_cpu(1'b1, 1'b0, 20'h00200, 8'h00);
        iVidReq = 1'b0;
        pulse_cpu(1'b0, 1'b1, 20'h00300, 8'hEE);
        drain();
        c0 = cyc;
        cpu_q.push_back('{pat(20'h00300), c0 + 5, 1'b1});
        pulse_cpu(1'b1, 1'b0, 20'h00300, 8'h00);
        drain();

        // Reset in the middle of a write
        pulse_cpu(1'b0, 1'b1, 20'h00400, 8'h99);
        @(negedge iClk);
        check_eq("mid_wr_we", 32'(oSramWe), 1);
        #1 iRstN = 1'b0;
        probe = 1'b1;
        #1;
        check_eq("rst_mid_we", 32'(oSramWe), 0);
        check_eq("rst_mid_bus_released", 32'(ioSramData), 32'h5A);
        check_eq("rst_mid_addr", 32'(oSramAddr), 0);
        check_eq("rst_mid_cpu_data", 32'(oCpuRamDataR), 0);
        check_eq("rst_mid_vid_data", 32'(oVidData), 0);
        check_eq("rst_mid_ready", 32'(oCpuRamReady), 0);
        check_eq("rst_mid_ack", 32'(oVidAck), 0);
        probe = 1'b0;
        repeat (2) @(negedge iClk);
        iRstN = 1'b1;
        repeat (10) @(negedge iClk);
        check_eq("post_rst_we", 32'(oSramWe), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
